// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//
// Reads DATA_WIDTH-bit entries from a synchronous FIFO and packs PACK_RATIO
// consecutive entries into one wide word on a valid/ready stream. Lane 0
// (the LSBs) holds the oldest entry. A single-cycle flush emits a partially
// filled word together with its lane count.
//
// Storage is double-buffered: an assembly register collects lanes while the
// output register holds the word currently offered downstream. That lets up
// to 2*PACK_RATIO entries sit inside the block under backpressure.
//
// Ports:
//   i_Clk         clock, shared with the FIFO
//   i_Reset       asynchronous active-high reset
//   o_Rd_En       read request to the FIFO (combinational)
//   i_Empty       FIFO empty flag
//   i_Rd_Data     FIFO read data, valid when i_Data_Valid=1
//   i_Data_Valid  FIFO read data valid (one cycle after o_Rd_En)
//   i_Flush       single-cycle pulse: emit the partial word
//   o_Data        packed word, unused lanes zero
//   o_Count       number of valid lanes in o_Data (1..PACK_RATIO)
//   o_Valid       o_Data/o_Count valid
//   i_Ready       downstream accepts when o_Valid && i_Ready at a rising edge
//   o_Busy        assembly non-empty, read in flight or flush pending
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic                                 i_Clk,
  input  logic                                 i_Reset,
  output logic                                 o_Rd_En,
  input  logic                                 i_Empty,
  input  logic [DATA_WIDTH-1:0]                i_Rd_Data,
  input  logic                                 i_Data_Valid,
  input  logic                                 i_Flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0]     o_Data,
  output logic [$clog2(PACK_RATIO+1)-1:0]      o_Count,
  output logic                                 o_Valid,
  input  logic                                 i_Ready,
  output logic                                 o_Busy
);

  localparam int CNT_W = $clog2(PACK_RATIO + 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_HOLD,
    ST_FLUSH
  } state_t;

  state_t                            state_reg, state_next;
  logic [CNT_W-1:0]                  filled_reg, filled_next;
  logic                              inflight_reg, inflight_next;
  logic [DATA_WIDTH*PACK_RATIO-1:0]  data_reg;
  logic [CNT_W-1:0]                  count_reg;
  logic                              valid_reg;

  logic [CNT_W:0]                    occupancy;
  logic [DATA_WIDTH*PACK_RATIO-1:0]  packed_word;
  logic                              asm_full;
  logic                              capture;
  logic                              out_free;
  logic                              flush_done;
  logic                              do_transfer;

  // Lanes already captured plus the one still in flight; one extra bit so
  // the compare against PACK_RATIO can never wrap.
  assign occupancy  = {1'b0, filled_reg} + {{CNT_W{1'b0}}, inflight_reg};
  assign asm_full   = (filled_reg == CNT_W'(PACK_RATIO));

  // Never request a read that could not land in a free lane.
  assign o_Rd_En    = !i_Reset && !i_Empty && (state_reg != ST_FLUSH) &&
                      (occupancy < (CNT_W + 1)'(PACK_RATIO));

  assign capture    = i_Data_Valid && !asm_full;
  assign out_free   = !valid_reg || i_Ready;
  assign flush_done = (state_reg == ST_FLUSH) && !inflight_reg;
  assign do_transfer = out_free &&
                       (asm_full || (flush_done && (filled_reg != '0)));

  // One register per lane; lanes at or above the fill level read as zero so a
  // partial word never exposes stale data from an earlier word.
  genvar gi;
  generate
    for (gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_reg;

      always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
          lane_reg <= '0;
        end else if (capture && (filled_reg == CNT_W'(gi))) begin
          lane_reg <= i_Rd_Data;
        end
      end

      assign packed_word[gi*DATA_WIDTH +: DATA_WIDTH] =
        (CNT_W'(gi) < filled_reg) ? lane_reg : '0;
    end
  endgenerate

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg    <= ST_FILL;
      filled_reg   <= '0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      filled_reg   <= filled_next;
      inflight_reg <= inflight_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    filled_next   = filled_reg;
    inflight_next = inflight_reg;

    // A transfer only happens with no read pending into the assembly, so it
    // never coincides with a capture.
    if (do_transfer) begin
      filled_next = '0;
    end else if (capture) begin
      filled_next = filled_reg + CNT_W'(1);
    end

    // A new request and the landing of the previous one may share a cycle.
    if (o_Rd_En) begin
      inflight_next = 1'b1;
    end else if (i_Data_Valid) begin
      inflight_next = 1'b0;
    end

    case (state_reg)
      ST_FILL: begin
        if (i_Flush) begin
          state_next = ST_FLUSH;
        end else if (asm_full && !do_transfer) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_Flush) begin
          state_next = ST_FLUSH;
        end else if (do_transfer) begin
          state_next = ST_FILL;
        end
      end
      ST_FLUSH: begin
        // Further flush pulses are ignored here. Done once the last read has
        // landed and the partial word (if any) has moved to the output.
        if (!inflight_reg && ((filled_reg == '0) || do_transfer)) begin
          state_next = ST_FILL;
        end
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      data_reg  <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
    end else if (do_transfer) begin
      data_reg  <= packed_word;
      count_reg <= filled_reg;
      valid_reg <= 1'b1;
    end else if (valid_reg && i_Ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign o_Data  = data_reg;
  assign o_Count = count_reg;
  assign o_Valid = valid_reg;
  assign o_Busy  = (filled_reg != '0) || inflight_reg || (state_reg == ST_FLUSH);

endmodule
